// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: word type, NOP encoding and
// instruction field positions used by fetch and decode.
package cpu_pkg;

    typedef logic [31:0] word_t;

    // All-zero word decodes as sll $0,$0,0, a harmless no-op.
    localparam word_t NOP_INST = 32'h0000_0000;

    // Instruction field positions.
    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int JIDX_HI   = 25;
    localparam int JIDX_LO   = 0;
    localparam int IMM_HI    = 15;
    localparam int IMM_LO    = 0;

    // Major opcode of an instruction word.
    function automatic logic [5:0] opcode_of(input word_t inst);
        return inst[OPCODE_HI:OPCODE_LO];
    endfunction

    // Sign-extended, word-scaled branch displacement.
    function automatic word_t branch_offset(input word_t inst);
        return {{14{inst[IMM_HI]}}, inst[IMM_HI:IMM_LO], 2'b00};
    endfunction

    // Pseudo-direct jump target formed from the delay-free PC+4.
    function automatic word_t jump_target(input word_t pc4, input word_t inst);
        return {pc4[31:28], inst[JIDX_HI:JIDX_LO], 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, jump or taken branch.
// A redirect only counts when the instruction in ID is real; jump wins
// over branch if decode raises both.
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] id_pc4,
    input  logic [31:0] id_inst,
    input  logic        jump,
    input  logic        branch_taken,
    input  logic        id_valid,
    output logic [31:0] next_pc,
    output logic        redir
);

    // Opcode bits are decode's business; they do not affect the target.
    logic unused_opcode;
    assign unused_opcode = ^opcode_of(id_inst);

    // Pick the next PC by redirect kind.
    always_comb begin
        next_pc = pc + 32'd4;
        redir   = id_valid & (jump | branch_taken);
        if (redir) begin
            if (jump) begin
                next_pc = jump_target(id_pc4, id_inst);
            end else begin
                next_pc = id_pc4 + branch_offset(id_inst);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, zero-latency ROM addressing,
// IF/ID pipeline register, sticky range fault and delivered-fetch counter.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 32,
    parameter logic [31:0] NOP_INST   = cpu_pkg::NOP_INST
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Jump,
    input  logic        BranchTaken,
    input  logic [31:0] Inst,
    output logic [31:0] Addr,
    output logic [31:0] ID_Inst,
    output logic [31:0] ID_PC4,
    output logic        ID_Valid,
    output logic        Fault,
    output logic [31:0] FetchCount
);

    // Byte-address bits that lie inside the ROM; anything above is a fault.
    localparam int AW = $clog2(IMEM_WORDS) + 2;

    logic [31:0] pc_q;
    logic [31:0] next_pc;
    logic        redir;
    logic        out_of_range;

    assign Addr = pc_q;

    next_pc_calc u_next_pc_calc (
        .pc           (pc_q),
        .id_pc4       (ID_PC4),
        .id_inst      (ID_Inst),
        .jump         (Jump),
        .branch_taken (BranchTaken),
        .id_valid     (ID_Valid),
        .next_pc      (next_pc),
        .redir        (redir)
    );

    // Any set bit above the ROM index range means the target is illegal.
    always_comb begin
        out_of_range = (next_pc >> AW) != 32'd0;
    end

    // PC, IF/ID, fault and counter update. Priority: reset, fault, stall,
    // then a PC load (which may itself raise the fault, redirect, or fetch).
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q       <= RESET_PC;
            ID_Inst    <= NOP_INST;
            ID_PC4     <= 32'd0;
            ID_Valid   <= 1'b0;
            Fault      <= 1'b0;
            FetchCount <= 32'd0;
        end else if (Fault) begin
            ID_Inst  <= NOP_INST;
            ID_PC4   <= 32'd0;
            ID_Valid <= 1'b0;
        end else if (!Stall) begin
            // The offending address is kept in the PC so it shows on Addr.
            pc_q <= next_pc;
            if (out_of_range || redir) begin
                Fault    <= out_of_range;
                ID_Inst  <= NOP_INST;
                ID_PC4   <= 32'd0;
                ID_Valid <= 1'b0;
            end else begin
                ID_Inst    <= Inst;
                ID_PC4     <= next_pc;
                ID_Valid   <= 1'b1;
                FetchCount <= FetchCount + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural zero-latency ROM.
module tb_fetch_unit;

    logic        Clk;
    logic        Reset;
    logic        Stall;
    logic        Jump;
    logic        BranchTaken;
    logic [31:0] Inst;
    logic [31:0] Addr;
    logic [31:0] ID_Inst;
    logic [31:0] ID_PC4;
    logic        ID_Valid;
    logic        Fault;
    logic [31:0] FetchCount;

    logic [31:0] rom [0:31];
    logic [31:0] exp_q [$];

    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Stall       (Stall),
        .Jump        (Jump),
        .BranchTaken (BranchTaken),
        .Inst        (Inst),
        .Addr        (Addr),
        .ID_Inst     (ID_Inst),
        .ID_PC4      (ID_PC4),
        .ID_Valid    (ID_Valid),
        .Fault       (Fault),
        .FetchCount  (FetchCount)
    );

    // Zero-latency ROM indexed by word address.
    assign Inst = rom[Addr[6:2]];

    // Clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // One rising edge, then settle before sampling.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    task automatic set_flags(input logic s, input logic j, input logic b);
        Stall = s;
        Jump = j;
        BranchTaken = b;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 32'h2000_0000 | i;  // addi-like filler
        rom[0]  = 32'h0800_0005;  // j 5
        rom[3]  = 32'h0800_0005;  // j 5
        rom[7]  = 32'h1000_FFFF;  // beq, imm -1
        rom[14] = 32'h1000_123F;  // beq, imm 0x123F

        Reset = 1'b0;
        set_flags(1'b0, 1'b0, 1'b0);
        #2;
        do_reset();

        // Reset state
        check("rst_addr", Addr, 32'h0);
        check("rst_valid", {31'd0, ID_Valid}, 32'd0);
        check("rst_inst", ID_Inst, 32'h0);
        check("rst_pc4", ID_PC4, 32'h0);
        check("rst_fault", {31'd0, Fault}, 32'd0);
        check("rst_count", FetchCount, 32'd0);

        // Four free-running fetches
        step();
        check("seq1_inst", ID_Inst, 32'h0800_0005);
        check("seq1_pc4", ID_PC4, 32'h4);
        check("seq1_valid", {31'd0, ID_Valid}, 32'd1);
        check("seq1_count", FetchCount, 32'd1);
        check("seq1_addr", Addr, 32'h4);
        step();
        check("seq2_addr", Addr, 32'h8);
        step();
        check("seq3_addr", Addr, 32'hC);
        step();
        check("seq4_addr", Addr, 32'h10);
        check("seq4_count", FetchCount, 32'd4);
        check("seq4_inst", ID_Inst, 32'h0800_0005);

        // Jump in ID
        set_flags(1'b0, 1'b1, 1'b0);
        step();
        set_flags(1'b0, 1'b0, 1'b0);
        check("jmp_addr", Addr, 32'h14);
        check("jmp_valid", {31'd0, ID_Valid}, 32'd0);
        check("jmp_count", FetchCount, 32'd4);
        step();
        check("jmp_pc4", ID_PC4, 32'h18);
        check("jmp_valid2", {31'd0, ID_Valid}, 32'd1);
        check("jmp_inst2", ID_Inst, 32'h2000_0005);
        check("jmp_count2", FetchCount, 32'd5);

        // Backward branch by one word: beq at 0x1C loops to itself
        step();
        step();
        check("beq_pre_pc4", ID_PC4, 32'h20);
        check("beq_pre_inst", ID_Inst, 32'h1000_FFFF);
        set_flags(1'b0, 1'b0, 1'b1);
        step();
        set_flags(1'b0, 1'b0, 1'b0);
        check("beq_addr", Addr, 32'h1C);
        check("beq_valid", {31'd0, ID_Valid}, 32'd0);
        check("beq_count", FetchCount, 32'd7);
        step();
        check("beq_valid2", {31'd0, ID_Valid}, 32'd1);
        check("beq_pc4_2", ID_PC4, 32'h20);
        check("beq_count2", FetchCount, 32'd8);

        // Stall held with Jump for three cycles, then jump resolves
        do_reset();
        step();
        set_flags(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addr", Addr, 32'h4);
            check("stall_inst", ID_Inst, 32'h0800_0005);
            check("stall_count", FetchCount, 32'd1);
        end
        set_flags(1'b0, 1'b1, 1'b0);
        step();
        set_flags(1'b0, 1'b0, 1'b0);
        check("unstall_addr", Addr, 32'h14);
        check("unstall_valid", {31'd0, ID_Valid}, 32'd0);

        // Far branch out of ROM range raises the fault
        do_reset();
        for (int i = 0; i < 15; i++) step();
        check("far_pre_pc4", ID_PC4, 32'h3C);
        check("far_pre_inst", ID_Inst, 32'h1000_123F);
        set_flags(1'b0, 1'b0, 1'b1);
        step();
        set_flags(1'b0, 1'b0, 1'b0);
        check("far_addr", Addr, 32'h4938);
        check("far_fault", {31'd0, Fault}, 32'd1);
        check("far_valid", {31'd0, ID_Valid}, 32'd0);
        step();
        step();
        check("far_hold_addr", Addr, 32'h4938);
        check("far_hold_valid", {31'd0, ID_Valid}, 32'd0);
        check("far_hold_count", FetchCount, 32'd15);
        do_reset();
        check("far_rst_fault", {31'd0, Fault}, 32'd0);
        check("far_rst_addr", Addr, 32'h0);

        // Reset wins over a qualified branch
        step();
        check("rwin_pre_valid", {31'd0, ID_Valid}, 32'd1);
        Reset = 1'b1;
        set_flags(1'b0, 1'b0, 1'b1);
        step();
        Reset = 1'b0;
        set_flags(1'b0, 1'b0, 1'b0);
        check("rwin_addr", Addr, 32'h0);
        check("rwin_valid", {31'd0, ID_Valid}, 32'd0);
        check("rwin_count", FetchCount, 32'd0);

        // Full sequential sweep; the scoreboard predicts each delivered word
        for (int i = 0; i < 32; i++) begin
            if (i < 31) exp_q.push_back(rom[i]);
            step();
            if (i < 31) begin
                check("sweep_inst", ID_Inst, exp_q.pop_front());
                check("sweep_addr", Addr, 32'(4 * (i + 1)));
            end
        end
        check("wrap_addr", Addr, 32'h80);
        check("wrap_fault", {31'd0, Fault}, 32'd1);
        check("wrap_valid", {31'd0, ID_Valid}, 32'd0);
        check("wrap_count", FetchCount, 32'd31);
        step();
        check("wrap_hold_addr", Addr, 32'h80);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the MIPS core. It holds the PC, drives the word address into the combinational instruction ROM, and captures the returned instruction into an IF/ID pipeline register. It computes the next PC (sequential, branch, or jump) from control flags supplied by decode. It also handles stall, flush, out-of-range fault, and a fetch counter.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IMEM_WORDS, 32, instruction ROM depth in words (power of two); legal PC range is 0 .. IMEM_WORDS*4-4
NOP_INST, 32'h0000_0000, instruction word inserted into IF/ID on flush, fault or reset

Ports:
Clk  input  1  system clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Stall  input  1  from hazard unit; hold PC and IF/ID
Jump  input  1  decode: instruction in ID is j
BranchTaken  input  1  decode: instruction in ID is beq/bne and its condition is true
Inst  input  32  instruction word returned by ROM for Addr (same cycle, combinational)
Addr  output  32  byte address to ROM; equals PC register
ID_Inst  output  32  IF/ID instruction register
ID_PC4  output  32  IF/ID register holding PC+4 of ID_Inst
ID_Valid  output  1  IF/ID holds a real (not squashed) instruction
Fault  output  1  sticky: PC left legal ROM range
FetchCount  output  32  number of valid instructions delivered to ID

Behaviour:
- Reset (any cycle, including mid-stall or mid-redirect): PC=RESET_PC, ID_Inst=NOP_INST, ID_PC4=0, ID_Valid=0, Fault=0, FetchCount=0. Reset wins over all other inputs.
- Addr = PC, combinational. ROM latency is zero; Inst is valid in the same cycle.
- Redirect is qualified: Redir = ID_Valid & (Jump | BranchTaken). Jump has priority over BranchTaken if both are set.
- Jump target = {ID_PC4[31:28], ID_Inst[25:0], 2'b00}.
- Branch target = ID_PC4 + {{14{ID_Inst[15]}}, ID_Inst[15:0], 2'b00}. Mod-2^32 wrap; no overflow flag.
- Per-edge priority when not in reset:
  1. Fault=1: PC holds; IF/ID loads NOP with ID_Valid=0; FetchCount holds.
  2. Stall=1: PC, IF/ID and FetchCount all hold. Redir is ignored; decode keeps its flags asserted until the stall clears.
  3. Redir: PC=target. IF/ID loads NOP with ID_Valid=0, squashing the wrong-path fetch. There is no delay slot.
  4. Otherwise: PC=PC+4; ID_Inst=Inst, ID_PC4=PC+4, ID_Valid=1; FetchCount+1 (wraps at 2^32).
- Fault detection: on any edge where PC is loaded with NextPC and NextPC[31:log2(IMEM_WORDS)+2] != 0:
  - Fault is set and PC still takes NextPC, so the offending address stays observable on Addr.
  - IF/ID loads NOP with ID_Valid=0.
  - Fault is cleared only by Reset.
- Sequential wrap 0x7C -> 0x80 (IMEM_WORDS=32) counts as a fault.
- Target alignment: targets are word-aligned by construction; PC[1:0] is always 0.
- Latency: an instruction at address A appears on ID_Inst one edge after PC==A. A redirect costs exactly one bubble.

Decomposition:
- Shared package cpu_pkg:
  - NOP_INST constant.
  - Opcode field positions: [31:26], [25:0], [15:0].
  - Type/width of the 32-bit word.
- One natural sub-module: next_pc_calc, combinational. Inputs: PC, ID_PC4, ID_Inst, Jump, BranchTaken, ID_Valid. Outputs: NextPC, Redir.
- PC, IF/ID, Fault and counter registers stay in fetch_unit.

Test Plan:
- Reset then 4 free-running cycles with ROM word0=0x0800_0005 -> Addr 0x0,0x4,0x8,0xC. After edge 1: ID_Inst=0x0800_0005, ID_PC4=0x4, ID_Valid=1. FetchCount=1 after edge 1, 4 after edge 4.
- j 5H in ID, Jump=1 -> next edge: Addr=0x14, ID_Valid=0, FetchCount unchanged. Following edge: ID_PC4=0x18, ID_Valid=1.
- beq with imm 0xFFFF in ID, ID_PC4=0x20, BranchTaken=1 -> Addr=0x1C, one bubble.
- beq imm 0x123F at PC 0x38 (ID_PC4=0x3C), BranchTaken=1 -> Addr=0x4938, Fault=1. Subsequent edges: Addr stays 0x4938, ID_Valid=0. Reset -> Fault=0, Addr=0.
- Stall=1 together with Jump=1 for 3 cycles -> Addr, ID_Inst and FetchCount frozen. Stall drops -> jump is taken on the next edge.
- Reset asserted in the same cycle as BranchTaken, with ID_Valid=1 -> Addr=RESET_PC, ID_Valid=0, FetchCount=0. Sequential fetch from 0x0 to 0x7C, then next edge -> Addr=0x80, Fault=1.
